// File: rtl/unidad_calculo_param.sv
// unidad_calculo_param: small register-file calculator. Each command walks
// IDLE -> READ -> EXEC -> WRITE and completes with a one-cycle done_o pulse,
// one cycle after WRITE, which is the same cycle the register write becomes visible.
module unidad_calculo_param #(
    parameter  int WIDTH  = 16,
    parameter  int NREGS  = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              cmd_valid_i,
    output logic              cmd_ready_o,
    input  logic [3:0]        cmd_op_i,
    input  logic [ADDR_W-1:0] cmd_rd_i,
    input  logic [ADDR_W-1:0] cmd_rs1_i,
    input  logic [ADDR_W-1:0] cmd_rs2_i,
    input  logic [WIDTH-1:0]  cmd_imm_i,
    input  logic              cmd_flag_i,
    output logic [WIDTH-1:0]  result_o,
    output logic [1:0]        flags_o,
    output logic              done_o,
    output logic              err_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [WIDTH-1:0]  dbg_data_o
);

    localparam int SH_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_WRITE = 2'd3;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SHL   = 4'd5;
    localparam logic [3:0] OP_SHR   = 4'd6;
    localparam logic [3:0] OP_PASS  = 4'd7;
    localparam logic [3:0] OP_LOADI = 4'd8;

    logic [1:0]        state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [ADDR_W-1:0] rs1_q, rs1_d;
    logic [ADDR_W-1:0] rs2_q, rs2_d;
    logic [WIDTH-1:0]  imm_q, imm_d;
    logic              cin_q, cin_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  result_q, result_d;
    logic [1:0]        flags_q, flags_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [WIDTH-1:0]  regs_q [NREGS];
    logic [WIDTH-1:0]  regs_d [NREGS];

    logic [WIDTH:0]    sum_ext;
    logic [WIDTH:0]    diff_ext;
    logic [WIDTH-1:0]  alu_res;
    logic              alu_carry;
    logic              op_legal;

    // Opcodes above LOADI are illegal and leave all architectural state alone.
    assign op_legal    = (op_q <= OP_LOADI);
    assign cmd_ready_o = (state_q == S_IDLE) && !reset_i;
    assign result_o    = result_q;
    assign flags_o     = flags_q;
    assign done_o      = done_q;
    assign err_o       = err_q;
    // Register 0 is hard-wired to zero on every read path.
    assign dbg_data_o  = (dbg_addr_i == '0) ? '0 : regs_q[dbg_addr_i];

    // ALU on the registered operands; the carry of SUB is the borrow out of the extended difference.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
        alu_res   = '0;
        alu_carry = 1'b0;
        sum_ext   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
        diff_ext  = {1'b0, a_q} - {1'b0, b_q} - {{WIDTH{1'b0}}, cin_q};
        case (op_q)
            OP_ADD: begin
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
            end
            OP_SUB: begin
                alu_res   = diff_ext[WIDTH-1:0];
                alu_carry = diff_ext[WIDTH];
            end
            OP_AND:   alu_res = a_q & b_q;
            OP_OR:    alu_res = a_q | b_q;
            OP_XOR:   alu_res = a_q ^ b_q;
            OP_SHL:   alu_res = a_q << b_q[SH_W-1:0];
            OP_SHR:   alu_res = a_q >> b_q[SH_W-1:0];
            OP_PASS:  alu_res = a_q;
            OP_LOADI: alu_res = imm_q;
            default:  alu_res = '0;
        endcase
    end

    // Sequencer: capture on accept, read operands, execute, then commit the write and pulse done.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        rs1_d    = rs1_q;
        rs2_d    = rs2_q;
        imm_d    = imm_q;
        cin_d    = cin_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        flags_d  = flags_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        regs_d   = regs_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    op_d    = cmd_op_i;
                    rd_d    = cmd_rd_i;
                    rs1_d   = cmd_rs1_i;
                    rs2_d   = cmd_rs2_i;
                    imm_d   = cmd_imm_i;
                    cin_d   = cmd_flag_i;
                    state_d = S_READ;
                end
            end
            S_READ: begin
                a_d     = (rs1_q == '0) ? '0 : regs_q[rs1_q];
                b_d     = (rs2_q == '0) ? '0 : regs_q[rs2_q];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_legal) begin
                    result_d = alu_res;
                    flags_d  = {alu_carry, (alu_res == '0)};
                end
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (op_legal && (rd_q != '0)) begin
                    regs_d[rd_q] = result_q;
                end
                done_d  = 1'b1;
                err_d   = !op_legal;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; reset also aborts any command in flight.
    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset_i) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            rs1_q    <= '0;
            rs2_q    <= '0;
            imm_q    <= '0;
            cin_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= 2'b01;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            // NOTE: the register file is architecturally cleared by reset, so it is built from resettable flops, not a RAM.
            regs_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            rs1_q    <= rs1_d;
            rs2_q    <= rs2_d;
            imm_q    <= imm_d;
            cin_q    <= cin_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            done_q   <= done_d;
            err_q    <= err_d;
            regs_q   <= regs_d;
        end
    end

endmodule

// File: tb/tb_unidad_calculo_param.sv
// Self-checking bench for unidad_calculo_param: directed cases plus random
// commands compared against an arithmetic reference model of the register file.
module tb_unidad_calculo_param;

    localparam int W   = 16;
    localparam int N   = 32;
    localparam int AW  = 5;
    localparam int MOD = 1 << W;

    logic          clk;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_op;
    logic [AW-1:0] cmd_rd, cmd_rs1, cmd_rs2;
    logic [W-1:0]  cmd_imm;
    logic          cmd_flag;
    logic [W-1:0]  result;
    logic [1:0]    flags;
    logic          done, err;
    logic [AW-1:0] dbg_addr;
    logic [W-1:0]  dbg_data;

    logic          c8_valid, c8_ready;
    logic [3:0]    c8_op;
    logic [2:0]    c8_rd, c8_rs1, c8_rs2;
    logic [7:0]    c8_imm;
    logic          c8_flag;
    logic [7:0]    c8_result;
    logic [1:0]    c8_flags;
    logic          c8_done, c8_err;
    logic [2:0]    c8_dbg_addr;
    logic [7:0]    c8_dbg_data;

    int total = 0;
    int bad   = 0;
    int mregs [N];
    int mres;
    int mflags;

    unidad_calculo_param #(.WIDTH(16), .NREGS(32)) dut (
        .clk_i(clk), .reset_i(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
        .cmd_op_i(cmd_op), .cmd_rd_i(cmd_rd), .cmd_rs1_i(cmd_rs1), .cmd_rs2_i(cmd_rs2),
        .cmd_imm_i(cmd_imm), .cmd_flag_i(cmd_flag),
        .result_o(result), .flags_o(flags), .done_o(done), .err_o(err),
        .dbg_addr_i(dbg_addr), .dbg_data_o(dbg_data)
    );

    unidad_calculo_param #(.WIDTH(8), .NREGS(8)) dut8 (
        .clk_i(clk), .reset_i(rst),
        .cmd_valid_i(c8_valid), .cmd_ready_o(c8_ready),
        .cmd_op_i(c8_op), .cmd_rd_i(c8_rd), .cmd_rs1_i(c8_rs1), .cmd_rs2_i(c8_rs2),
        .cmd_imm_i(c8_imm), .cmd_flag_i(c8_flag),
        .result_o(c8_result), .flags_o(c8_flags), .done_o(c8_done), .err_o(c8_err),
        .dbg_addr_i(c8_dbg_addr), .dbg_data_o(c8_dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour of one command, straight from the operation table.
    function automatic void ref_exec(input int op, input int a, input int b, input int cin, input int imm,
                                     output int res, output int carry, output bit legal);
        longint s;
        int     sh;
        sh    = b % W;
        res   = 0;
        carry = 0;
        legal = 1'b1;
        case (op)
            0: begin
                s     = longint'(a) + b + cin;
                res   = int'(s % MOD);
                carry = (s >= MOD) ? 1 : 0;
            end
            1: begin
                res   = (a - b - cin + 2 * MOD) % MOD;
                carry = (a < b + cin) ? 1 : 0;
            end
            2: res = a & b;
            3: res = a | b;
            4: res = a ^ b;
            5: begin
                s   = longint'(a) * (longint'(1) << sh);
                res = int'(s % MOD);
            end
            6: res = a / (1 << sh);
            7: res = a;
            8: res = imm;
            default: legal = 1'b0;
        endcase
    endfunction

    task automatic scramble_cmd();
        cmd_op   = 4'($urandom);
        cmd_rd   = AW'($urandom);
        cmd_rs1  = AW'($urandom);
        cmd_rs2  = AW'($urandom);
        cmd_imm  = W'($urandom);
        cmd_flag = 1'($urandom);
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) mregs[i] = 0;
        mres   = 0;
        mflags = 1;
    endtask

    // One full command on the 16-bit instance, checking timing, outputs and the register file.
    task automatic issue(input int op, input int rd, input int rs1, input int rs2, input int imm, input int cin);
        int res, carry, n, exp_res, exp_flags;
        bit legal;
        ref_exec(op, mregs[rs1], mregs[rs2], cin, imm, res, carry, legal);
        exp_res   = legal ? res : mres;
        exp_flags = legal ? (carry * 2 + ((res == 0) ? 1 : 0)) : mflags;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        cmd_valid = 1'b1;
        cmd_op    = 4'(op);
        cmd_rd    = AW'(rd);
        cmd_rs1   = AW'(rs1);
        cmd_rs2   = AW'(rs2);
        cmd_imm   = W'(imm);
        cmd_flag  = cin[0];
        n = 0;
        while (!cmd_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("accept_ready", cmd_ready, 1);
        @(negedge clk);
        check("busy_not_ready", cmd_ready, 0);
        cmd_valid = 1'($urandom);
        scramble_cmd();
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clk);
            check("done_early", done, 0);
        end
        cmd_valid = 1'b0;
        @(negedge clk);
        check("done", done, 1);
        check("err", err, legal ? 0 : 1);
        check("result", result, exp_res);
        check("flags", flags, exp_flags);
        check("ready_after_done", cmd_ready, 1);
        mres   = exp_res;
        mflags = exp_flags;
        if (legal && rd != 0) mregs[rd] = res;
        dbg_addr = AW'(rd);
        #1 check("dbg_rd", dbg_data, mregs[rd]);
        dbg_addr = AW'(rs1);
        #1 check("dbg_rs1", dbg_data, mregs[rs1]);
    endtask

    // One command on the 8-bit instance; returns once done_o has been seen.
    task automatic issue8(input int op, input int rd, input int rs1, input int rs2, input int imm);
        int n;
        @(negedge clk);
        c8_valid = 1'b1;
        c8_op    = 4'(op);
        c8_rd    = 3'(rd);
        c8_rs1   = 3'(rs1);
        c8_rs2   = 3'(rs2);
        c8_imm   = 8'(imm);
        c8_flag  = 1'b0;
        n = 0;
        while (!c8_ready && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("c8_accept", c8_ready, 1);
        @(negedge clk);
        c8_valid = 1'b0;
        n = 0;
        while (!c8_done && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("c8_done", c8_done, 1);
        check("c8_latency", n, 3);
        check("c8_err", c8_err, 0);
    endtask

    initial begin
        rst         = 1'b1;
        cmd_valid   = 1'b0;
        cmd_op      = '0;
        cmd_rd      = '0;
        cmd_rs1     = '0;
        cmd_rs2     = '0;
        cmd_imm     = '0;
        cmd_flag    = 1'b0;
        dbg_addr    = '0;
        c8_valid    = 1'b0;
        c8_op       = '0;
        c8_rd       = '0;
        c8_rs1      = '0;
        c8_rs2      = '0;
        c8_imm      = '0;
        c8_flag     = 1'b0;
        c8_dbg_addr = '0;
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", cmd_ready, 0);
        check("rst_result", result, 0);
        check("rst_flags", flags, 2'b01);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        dbg_addr = 5'd5;
        #1 check("rst_reg5", dbg_data, 0);
        rst = 1'b0;
        #1 check("ready_after_reset", cmd_ready, 1);

        // LOADI, then ADD/SUB with wrap and carry/borrow
        issue(8, 1, 0, 0, 'h1234, 0);
        issue(8, 1, 0, 0, 'hFFFF, 0);
        issue(8, 2, 0, 0, 'h0001, 0);
        issue(0, 3, 1, 2, 0, 0);
        issue(1, 4, 2, 1, 0, 0);
        issue(0, 7, 2, 2, 0, 1);
        issue(1, 8, 2, 2, 0, 1);
        issue(1, 9, 2, 2, 0, 0);

        // rd aliasing a source uses the pre-write value
        issue(0, 1, 1, 1, 0, 0);

        // Writes to register 0 are dropped; illegal opcode keeps result/flags
        issue(8, 0, 0, 0, 'h5555, 0);
        issue(12, 3, 1, 2, 'h7777, 1);
        issue(15, 0, 3, 4, 0, 0);

        // Logic and shift operations
        issue(8, 10, 0, 0, 'hA5F0, 0);
        issue(8, 11, 0, 0, 'h0F13, 0);
        issue(2, 12, 10, 11, 0, 0);
        issue(3, 13, 10, 11, 0, 0);
        issue(4, 14, 10, 11, 0, 0);
        issue(5, 15, 10, 11, 0, 0);
        issue(6, 16, 10, 11, 0, 0);
        issue(7, 17, 10, 0, 0, 0);

        // Back-to-back with valid held: LOADI r5=7 then PASS r6=r5
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd8;
        cmd_rd    = 5'd5;
        cmd_rs1   = 5'd0;
        cmd_rs2   = 5'd0;
        cmd_imm   = 16'd7;
        cmd_flag  = 1'b0;
        check("b2b_ready1", cmd_ready, 1);
        @(negedge clk);
        cmd_op    = 4'd7;
        cmd_rd    = 5'd6;
        cmd_rs1   = 5'd5;
        cmd_imm   = 16'hBEEF;
        repeat (3) @(negedge clk);
        check("b2b_done1", done, 1);
        check("b2b_ready2", cmd_ready, 1);
        @(negedge clk);
        check("b2b_accepted2", cmd_ready, 0);
        check("b2b_done_pulse", done, 0);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b_done2", done, 1);
        check("b2b_result", result, 7);
        dbg_addr = 5'd6;
        #1 check("b2b_reg6", dbg_data, 7);
        mregs[5] = 7;
        mregs[6] = 7;
        mres     = 7;
        mflags   = 0;

        // Random commands against the model
        for (int i = 0; i < 40; i++) begin
            int op;
            op = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9, 15)) : int'($urandom_range(0, 8));
            issue(op, $urandom_range(0, N - 1), $urandom_range(0, N - 1), $urandom_range(0, N - 1),
                  $urandom_range(0, MOD - 1), $urandom_range(0, 1));
        end

        // Reset during EXEC of LOADI r2=0xAAAA aborts the command
        issue(8, 2, 0, 0, 'h1111, 0);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd8;
        cmd_rd    = 5'd2;
        cmd_imm   = 16'hAAAA;
        check("abort_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check("ready_in_reset", cmd_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        #1;
        check("abort_done", done, 0);
        check("abort_err", err, 0);
        check("abort_result", result, 0);
        check("abort_flags", flags, 2'b01);
        check("abort_ready", cmd_ready, 1);
        dbg_addr = 5'd2;
        #1 check("abort_reg2", dbg_data, 0);
        @(negedge clk);
        check("abort_no_late_done", done, 0);
        #1 check("abort_reg2_late", dbg_data, 0);
        issue(0, 9, 2, 2, 0, 1);

        // 8-bit instance: shifts use only the low bits of B
        issue8(8, 1, 0, 0, 'h81);
        issue8(8, 2, 0, 0, 'h01);
        issue8(5, 3, 1, 2, 0);
        check("c8_shl_result", c8_result, 8'h02);
        check("c8_shl_flags", c8_flags, 2'b00);
        issue8(8, 4, 0, 0, 'h09);
        issue8(6, 5, 1, 4, 0);
        check("c8_shr_result", c8_result, 8'h40);
        check("c8_shr_flags", c8_flags, 2'b00);
        c8_dbg_addr = 3'd5;
        #1 check("c8_reg5", c8_dbg_data, 8'h40);
        c8_dbg_addr = 3'd3;
        #1 check("c8_reg3", c8_dbg_data, 8'h02);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidad_calculo_param.md
UNIDAD_CALCULO_PARAM -- requirements
Module: unidad_calculo_param

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, 16, datapath and register width in bits (minimum 8).
- NREGS, 32, number of registers (power of two, minimum 4).
- ADDR_W, $clog2(NREGS), derived localparam and not user-set.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, named as follows:
- clk_i, in, 1, single clock; all state updates on its rising edge.
- reset_i, in, 1, synchronous active-high reset.
REQ-003 The block SHALL have these ports, after clock and reset:
- cmd_valid_i, in, 1, command present.
- cmd_ready_o, out, 1, block can accept a command.
- cmd_op_i, in, 4, operation code.
- cmd_rd_i, in, ADDR_W, destination register.
- cmd_rs1_i, in, ADDR_W, source A register.
- cmd_rs2_i, in, ADDR_W, source B register.
- cmd_imm_i, in, WIDTH, immediate value for LOADI.
- cmd_flag_i, in, 1, carry/borrow-in for ADD/SUB.
- result_o, out, WIDTH, last computed result.
- flags_o, out, 2, {carry, zero} of last legal operation.
- done_o, out, 1, one-cycle pulse when a command completes.
- err_o, out, 1, one-cycle pulse with done_o for an illegal opcode.
- dbg_addr_i, in, ADDR_W, debug read address.
- dbg_data_o, out, WIDTH, combinational read of register dbg_addr_i.

Function
REQ-004 The FSM SHALL have four states, IDLE -> READ -> EXEC -> WRITE -> IDLE, with exactly one cycle in each non-IDLE state.
REQ-005 cmd_ready_o SHALL be 1 only in IDLE with reset_i low; a command is accepted on a cycle with cmd_valid_i=1 and cmd_ready_o=1.
REQ-006 On acceptance, the block SHALL capture all cmd_* fields; later changes to the inputs SHALL NOT affect that command.
REQ-007 READ SHALL register operand A = reg[rs1] and operand B = reg[rs2].
REQ-008 Register 0 SHALL always read 0, and writes to it SHALL be discarded.
REQ-009 EXEC SHALL compute and register result_o and flags_o; opcodes:
- 0 ADD: A+B+flag_in.
- 1 SUB: A-B-flag_in.
- 2 AND.
- 3 OR.
- 4 XOR.
- 5 SHL: A << B[$clog2(WIDTH)-1:0].
- 6 SHR: logical A >> B[$clog2(WIDTH)-1:0].
- 7 PASS: A.
- 8 LOADI: imm.
REQ-010 Arithmetic SHALL wrap modulo 2^WIDTH. ADD carry SHALL be bit WIDTH of the (WIDTH+1)-bit sum. SUB carry SHALL be the borrow, set when A < B+flag_in. Carry SHALL be 0 for opcodes 2-8.
REQ-011 The zero flag SHALL be 1 exactly when the WIDTH-bit result equals 0.
REQ-012 Opcodes 9-15 SHALL leave result_o, flags_o and the registers unchanged, and SHALL pulse err_o together with done_o.
REQ-013 In WRITE, for a legal opcode with rd != 0, the block SHALL write result_o to reg[rd]; done_o SHALL be high for that single cycle.
REQ-014 Latency: a command accepted at edge N SHALL give done_o high in the cycle after edge N+3, and the write SHALL be visible on dbg_data_o in that same cycle.
REQ-015 Throughput SHALL be one command per 4 cycles. A command accepted in the IDLE cycle right after WRITE SHALL read the updated register, with no hazard.
REQ-016 rd equal to rs1 or rs2 SHALL use the pre-write operand value.
REQ-017 result_o and flags_o SHALL hold their values until the next legal EXEC.
REQ-018 cmd_valid_i outside IDLE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-019 While reset_i is high at a clock edge, the block SHALL set:
- all registers to 0;
- state to IDLE;
- result_o=0, flags_o=2'b01, done_o=0, err_o=0.
REQ-020 cmd_ready_o SHALL be 0 whenever reset_i is high.
REQ-021 Reset asserted mid-command SHALL abort the command: no register write, no done_o, no err_o.
REQ-022 The first command SHALL be acceptable in the first cycle after reset_i falls.

Verification
REQ-023 LOADI rd=1 imm=0x1234 -> done_o at accept+4 cycles; dbg_addr_i=1 reads 0x1234; flags_o=00.
REQ-024 reg1=0xFFFF, reg2=0x0001, ADD rd=3 flag_in=0 -> result 0x0000, flags_o=11; SUB rd=4 rs1=2 rs2=1 -> result 0x0002, carry=1.
REQ-025 Back-to-back: LOADI rd=5 imm=7 then PASS rs1=5 rd=6 held valid -> second accept in first IDLE after done; reg6=7.
REQ-026 Write rd=0, and opcode 12 -> reg0 stays 0; the opcode-12 command gives err_o=done_o=1 for one cycle; result_o and flags unchanged.
REQ-027 Reset asserted during EXEC of LOADI rd=2 imm=0xAAAA -> reg2=0, no done_o, cmd_ready_o=1 one cycle after reset falls.
REQ-028 WIDTH=8, NREGS=8, SHL A=0x81 B=1 -> result 0x02, carry 0; SHR B=9 -> shift by 1 (B masked), result 0x40.
